// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: two-digit common-anode seven-segment scan controller.
// Splits a 0-15 value into tens/ones digits and scans them with blanking gaps.
// New values are taken only at frame boundaries (GAP_T -> SHOW_O).
// Optional macro SEG_LAMP_TEST_EN adds a lamp_test input that lights every
// segment during the SHOW slots.
module seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned GAP_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] value,
`ifdef SEG_LAMP_TEST_EN
    input  logic       lamp_test,
`endif
    output logic       upd_done,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int unsigned CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam logic [6:0]  SEG_OFF = 7'b1111111;

    typedef enum logic [1:0] {
        SHOW_O = 2'd0,
        GAP_O  = 2'd1,
        SHOW_T = 2'd2,
        GAP_T  = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         disp;
    logic [3:0]         pend;
    logic               pend_flag;

    state_t             state_nx_c;
    logic [CNT_W-1:0]   cnt_nx_c;
    logic [3:0]         disp_nx_c;
    logic               upd_nx_c;
    logic               last_c;
    logic               boundary_c;
    logic               tens_c;
    logic [3:0]         ones_c;
    logic [6:0]         seg_nx_c;
    logic [1:0]         an_nx_c;
    logic               lamp_c;

    // Active-low {a..g} pattern for one decimal digit
    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'b0000001;
            4'd1:    enc = 7'b1001111;
            4'd2:    enc = 7'b0010010;
            4'd3:    enc = 7'b0000110;
            4'd4:    enc = 7'b1001100;
            4'd5:    enc = 7'b0100100;
            4'd6:    enc = 7'b0100000;
            4'd7:    enc = 7'b0001111;
            4'd8:    enc = 7'b0000000;
            4'd9:    enc = 7'b0001100;
            default: enc = SEG_OFF;
        endcase
    endfunction

`ifdef SEG_LAMP_TEST_EN
    assign lamp_c = lamp_test;
`else
    assign lamp_c = 1'b0;
`endif

    // Next state, counter, displayed value and the outputs for the next state
    always_comb begin
        state_nx_c = state;
        cnt_nx_c   = cnt + CNT_W'(1);
        disp_nx_c  = disp;
        upd_nx_c   = 1'b0;
        seg_nx_c   = SEG_OFF;
        an_nx_c    = 2'b11;

        if (state == SHOW_O || state == SHOW_T)
            last_c = (cnt == CNT_W'(REFRESH_DIV - 1));
        else
            last_c = (cnt == CNT_W'(GAP_CYCLES - 1));

        boundary_c = last_c && (state == GAP_T);

        if (last_c) begin
            cnt_nx_c = '0;
            case (state)
                SHOW_O:  state_nx_c = GAP_O;
                GAP_O:   state_nx_c = SHOW_T;
                SHOW_T:  state_nx_c = GAP_T;
                default: state_nx_c = SHOW_O;
            endcase
        end

        // A load landing on the boundary edge bypasses the pending register
        if (boundary_c && load) begin
            disp_nx_c = value;
            upd_nx_c  = 1'b1;
        end else if (boundary_c && pend_flag) begin
            disp_nx_c = pend;
            upd_nx_c  = 1'b1;
        end

        tens_c = (disp_nx_c >= 4'd10);
        ones_c = tens_c ? (disp_nx_c - 4'd10) : disp_nx_c;

        case (state_nx_c)
            SHOW_O: begin
                an_nx_c  = 2'b10;
                seg_nx_c = lamp_c ? 7'b0000000 : enc(ones_c);
            end
            SHOW_T: begin
                an_nx_c  = 2'b01;
                if (lamp_c)
                    seg_nx_c = 7'b0000000;
                else if (tens_c)
                    seg_nx_c = enc(4'd1);
                else
                    seg_nx_c = SEG_OFF;
            end
            default: begin
                an_nx_c  = 2'b11;
                seg_nx_c = SEG_OFF;
            end
        endcase
    end

    // Scan FSM, pending-value capture and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= GAP_T;
            cnt       <= '0;
            disp      <= 4'd0;
            pend      <= 4'd0;
            pend_flag <= 1'b0;
            upd_done  <= 1'b0;
            seg       <= SEG_OFF;
            an        <= 2'b11;
        end else begin
            state    <= state_nx_c;
            cnt      <= cnt_nx_c;
            disp     <= disp_nx_c;
            upd_done <= upd_nx_c;
            seg      <= seg_nx_c;
            an       <= an_nx_c;
            if (boundary_c) begin
                pend_flag <= 1'b0;
            end else if (load) begin
                pend      <= value;
                pend_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl with REFRESH_DIV=4, GAP_CYCLES=2 (12-cycle frame).
// Stimulus pushes the expected {upd_done, an, seg} for every clock; a monitor
// pops and compares one entry per cycle on the falling edge.
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [3:0] value = 4'd0;
    logic       lamp = 1'b0;
    logic       upd_done;
    logic [6:0] seg;
    logic [1:0] an;

    logic [9:0] exp_q[$];
    logic       stim_done = 1'b0;
    int         checks = 0;
    int         fails = 0;
    int         cycles = 0;

    localparam logic [6:0] OFF = 7'b1111111;

    seg_scan_ctrl #(.REFRESH_DIV(4), .GAP_CYCLES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .value    (value),
`ifdef SEG_LAMP_TEST_EN
        .lamp_test(lamp),
`endif
        .upd_done (upd_done),
        .seg      (seg),
        .an       (an)
    );

    always #5 clk = ~clk;

    // Drive one clock of inputs and queue the outputs expected after that edge
    task automatic cyc(input logic r, input logic ld, input logic [3:0] v,
                       input logic [1:0] ean, input logic [6:0] eseg, input logic eupd);
        rst   = r;
        load  = ld;
        value = v;
        exp_q.push_back({eupd, ean, eseg});
        @(posedge clk);
        #1;
    endtask

    // One full frame starting at the SHOW_O edge; up to two loads at given slot indices
    task automatic frame(input logic [6:0] os, input logic [6:0] ts, input logic up,
                         input int i1, input logic [3:0] v1,
                         input int i2, input logic [3:0] v2);
        for (int i = 0; i < 12; i++) begin
            logic       ld;
            logic [3:0] v;
            ld = (i == i1) || (i == i2);
            v  = (i == i2) ? v2 : ((i == i1) ? v1 : 4'd0);
            if (i < 4)
                cyc(1'b0, ld, v, 2'b10, os, up && (i == 0));
            else if (i < 6)
                cyc(1'b0, ld, v, 2'b11, OFF, 1'b0);
            else if (i < 10)
                cyc(1'b0, ld, v, 2'b01, ts, 1'b0);
            else
                cyc(1'b0, ld, v, 2'b11, OFF, 1'b0);
        end
    endtask

    initial begin
        // Reset, then GAP_T blanking before the first SHOW_O showing 0
        cyc(1'b1, 1'b0, 4'd0, 2'b11, OFF, 1'b0);
        cyc(1'b1, 1'b0, 4'd0, 2'b11, OFF, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, 2'b11, OFF, 1'b0);
        frame(7'b0000001, OFF, 1'b0, -1, 4'd0, -1, 4'd0);
        // Load 13 mid-SHOW_T: this frame still shows 0
        frame(7'b0000001, OFF, 1'b0, 7, 4'd13, -1, 4'd0);
        frame(7'b0000110, 7'b1001111, 1'b1, -1, 4'd0, -1, 4'd0);
        // Load 5 then 12 in one frame: only 12 is taken
        frame(7'b0000110, 7'b1001111, 1'b0, 1, 4'd5, 10, 4'd12);
        frame(7'b0010010, 7'b1001111, 1'b1, -1, 4'd0, -1, 4'd0);
        // Load 9 on the boundary edge itself
        frame(7'b0001100, OFF, 1'b1, 0, 4'd9, -1, 4'd0);
        frame(7'b0001100, OFF, 1'b0, -1, 4'd0, -1, 4'd0);
        // Reset during SHOW_O with 7 pending
        cyc(1'b0, 1'b0, 4'd0, 2'b10, 7'b0001100, 1'b0);
        cyc(1'b0, 1'b1, 4'd7, 2'b10, 7'b0001100, 1'b0);
        cyc(1'b1, 1'b0, 4'd0, 2'b11, OFF, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, 2'b11, OFF, 1'b0);
        frame(7'b0000001, OFF, 1'b0, -1, 4'd0, -1, 4'd0);
        frame(7'b0000001, OFF, 1'b0, -1, 4'd0, -1, 4'd0);
`ifdef SEG_LAMP_TEST_EN
        lamp = 1'b1;
        frame(7'b0000000, 7'b0000000, 1'b0, -1, 4'd0, -1, 4'd0);
        lamp = 1'b0;
        frame(7'b0000001, OFF, 1'b0, -1, 4'd0, -1, 4'd0);
`endif
        load = 1'b0;
        stim_done = 1'b1;
    end

    // Monitor: one comparison per queued cycle, plus drain and watchdog handling
    always @(negedge clk) begin
        logic [9:0] e;
        cycles <= cycles + 1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks = checks + 1;
            if ({upd_done, an, seg} !== e) begin
                fails = fails + 1;
                $display("FAIL scan_out at %0t: got upd=%b an=%b seg=%b, expected upd=%b an=%b seg=%b",
                         $time, upd_done, an, seg, e[9], e[8:7], e[6:0]);
            end
        end else if (stim_done) begin
            $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
            $finish;
        end
        if (cycles > 5000) begin
            checks = checks + 1;
            fails = fails + 1;
            $display("FAIL watchdog: got %0d cycles, expected completion within 5000", cycles);
            $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
            $finish;
        end
    end

endmodule
